mul_feeder: RTL and testbench
=============================

MUL_FEEDER -- requirements
Module: mul_feeder

Interface
REQ-001 SHALL have parameter MUL_LAT, default 6: cycles from the mul_start rising edge to a valid mul_op; legal range 2..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  upstream operand pair valid.
REQ-005 SHALL have port in_ready  output  1  feeder can accept an operand pair.
REQ-006 SHALL have port in_a  input  4  multiplicand, unsigned.
REQ-007 SHALL have port in_b  input  4  multiplier, unsigned.
REQ-008 SHALL have port mul_start  output  1  one-cycle start pulse to the sequential multiplier.
REQ-009 SHALL have port mul_a  output  4  operand a driven to the multiplier.
REQ-010 SHALL have port mul_b  output  4  operand b driven to the multiplier.
REQ-011 SHALL have port mul_op  input  8  product returned by the multiplier.
REQ-012 SHALL have port out_valid  output  1  captured product valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts product.
REQ-014 SHALL have port out_prod  output  8  captured product.
REQ-015 SHALL have port done_cnt  output  8  count of products delivered downstream.

Function
REQ-016 SHALL buffer operand pairs in a 2-entry FIFO; push on in_valid & in_ready; in_ready = FIFO not full.
REQ-017 SHALL implement FSM states IDLE, START, WAIT, HOLD.
REQ-018 IDLE: FIFO non-empty -> pop head into mul_a/mul_b at the same edge, go START; otherwise stay.
REQ-019 START: mul_start = 1 for exactly this one cycle; next edge loads down-counter with MUL_LAT, go WAIT.
REQ-020 WAIT: counter decrements each edge; at the edge where counter = 1, capture mul_op into out_prod, set out_valid, go HOLD.
REQ-021 HOLD: out_valid and out_prod stay stable until out_ready = 1; at that edge, clear out_valid, increment done_cnt, go IDLE.
REQ-022 mul_start SHALL be 0 in every state except START.
REQ-023 mul_a/mul_b SHALL hold stable from the pop edge until the next pop.
REQ-024 Latency: acceptance edge to out_valid rising = MUL_LAT + 2 cycles when FSM idle and FIFO empty (8 at default).
REQ-025 Push and pop on the same edge with FIFO occupancy 1 SHALL leave occupancy at 1, with the new pair at the head.
REQ-026 With FIFO full, in_ready = 0; in_valid SHALL be ignored without loss or corruption of stored entries.
REQ-027 FIFO SHALL preserve order; pointers wrap modulo 2.
REQ-028 done_cnt SHALL wrap 255 -> 0 without side effects.
REQ-029 out_ready while out_valid = 0 SHALL have no effect.
REQ-030 Throughput: at most one product per MUL_LAT + 3 cycles; no overlap of multiplier operations.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, FIFO empty, in_ready 1 (after reset release), mul_start 0, mul_a 0, mul_b 0, out_valid 0, out_prod 0, done_cnt 0, counter 0.
REQ-032 Reset during START, WAIT or HOLD SHALL abort the operation; the product is discarded and done_cnt is not incremented.
REQ-033 After rst_n rises, the first push SHALL be accepted on the first rising edge with in_valid = 1.

Verification
REQ-034 Single op: push a=3, b=5 with out_ready=1 and a multiplier model of latency 6 -> mul_start pulses once, out_valid rises 8 cycles after acceptance, out_prod=15, done_cnt=1.
REQ-035 Max operands: a=15, b=15 -> out_prod=225; a=0, b=9 -> out_prod=0.
REQ-036 Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_prod stable, no new mul_start; out_ready=1 -> next pair starts via IDLE.
REQ-037 FIFO full: push (2,3),(4,5),(6,7) back-to-back while busy -> third pair stalled by in_ready=0; products 6, 20, 42 delivered in order; done_cnt=3.
REQ-038 Reset mid-WAIT: assert rst_n=0 during counter=3 -> all outputs zero at once, no out_valid, done_cnt=0; a following push of (2,2) yields out_prod=4.
REQ-039 Wrap: deliver 256 products -> done_cnt reads 0.

Source files
------------

// File: rtl/mul_feeder.sv
// mul_feeder: buffers operand pairs in a 2-entry FIFO and sequences them one
// at a time through an external fixed-latency sequential multiplier, holding
// each product until the downstream consumer accepts it.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - operand pair handshake (in_a, in_b: 4-bit unsigned)
//   mul_start           - one-cycle start pulse to the multiplier
//   mul_a/mul_b         - operands held stable for the multiplier
//   mul_op              - 8-bit product returned by the multiplier
//   out_valid/out_ready - product handshake (out_prod: 8-bit)
//   done_cnt            - wrapping count of delivered products
module mul_feeder #(
  parameter int unsigned MUL_LAT = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic       mul_start,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  input  logic [7:0] mul_op,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_prod,
  output logic [7:0] done_cnt
);

  localparam int unsigned DW = 4;
  localparam int unsigned PW = 8;
  localparam int unsigned CW = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } pair_t;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  pair_t         fifo_q [2];
  pair_t         fifo_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          mul_start_q, mul_start_d;
  logic [DW-1:0] mul_a_q, mul_a_d;
  logic [DW-1:0] mul_b_q, mul_b_d;
  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] out_prod_q, out_prod_d;
  logic [PW-1:0] done_cnt_q, done_cnt_d;
  logic          push, pop;

  // Next-state: FSM sequencing plus FIFO bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    out_valid_d = out_valid_q;
    out_prod_d  = out_prod_q;
    done_cnt_d  = done_cnt_q;
    push        = in_valid & in_ready_q;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != 2'd0) begin
          pop     = 1'b1;
          mul_a_d = fifo_q[rd_ptr_q].a;
          mul_b_d = fifo_q[rd_ptr_q].b;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = CW'(MUL_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_prod_d  = mul_op;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + PW'(1);
          state_d     = S_IDLE;
        end
      end
    endcase

    // A push while popping at occupancy 1 lands in the other slot, which
    // becomes the new head once rd_ptr advances.
    if (push) begin
      fifo_d[wr_ptr_q] = '{a: in_a, b: in_b};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d     = count_q + 2'(push) - 2'(pop);
    in_ready_d  = (count_d != 2'd2);
    mul_start_d = (state_d == S_START);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_prod_q  <= '0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      out_valid_q <= out_valid_d;
      out_prod_q  <= out_prod_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_valid = out_valid_q;
  assign out_prod  = out_prod_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_mul_feeder.sv
// tb_mul_feeder: scoreboard bench for mul_feeder with a fixed-latency
// multiplier model. Inputs change 1 time unit after the rising edge; the
// monitor samples on the falling edge.
module tb_mul_feeder;

  localparam int unsigned MUL_LAT = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       mul_start;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic [7:0] mul_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_prod;
  logic [7:0] done_cnt;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb [$];
  int  cyc       = 0;
  int  acc_cyc   = 0;
  int  ms_cnt    = 0;
  int  stall_cnt = 0;
  bit  lat_en    = 0;
  bit  lat_armed = 0;
  bit  hold_chk  = 0;
  logic [7:0] held;
  logic       prev_ov = 1'b0;
  int  m_cnt;

  mul_feeder #(.MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_op    (mul_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: garbage until MUL_LAT cycles after mul_start rises.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      mul_op <= 8'h00;
    end else if (mul_start) begin
      m_cnt  <= MUL_LAT - 1;
      mul_op <= 8'hEE;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (m_cnt == 1) begin
      m_cnt  <= 0;
      mul_op <= 8'(mul_a) * 8'(mul_b);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: scoreboard push on acceptance, pop/compare on delivery.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(8'(in_a) * 8'(in_b));
        if (lat_en) begin
          acc_cyc   = cyc + 1;
          lat_armed = 1;
        end
      end
      if (in_valid && !in_ready) stall_cnt++;
      if (mul_start) ms_cnt++;
      if (out_valid && !prev_ov && lat_armed) begin
        check_eq("latency", 32'(cyc - acc_cyc), 32'(MUL_LAT + 2));
        lat_armed = 0;
        lat_en    = 0;
      end
      if (hold_chk && out_valid && !out_ready) check_eq("hold_stable", 32'(out_prod), 32'(held));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check_eq("sb_underflow", 32'(out_prod), 32'hFFFF_FFFF);
        else check_eq("prod", 32'(out_prod), 32'(sb.pop_front()));
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one pair; returns one edge after acceptance (posedge + 1 phase).
  task automatic push(input logic [3:0] a, input logic [3:0] b);
    bit acc;
    int t;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    t        = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) check_eq("push_timeout", 32'(t), 32'(0));
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((sb.size() != 0 || out_valid) && t < budget) begin
      step(1);
      t++;
    end
    if (t >= budget) check_eq("drain_timeout", 32'(sb.size()), 32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    sb.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    int t;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    step(2);
    check_eq("rst_in_ready", 32'(in_ready), 32'(1));
    check_eq("rst_mul_start", 32'(mul_start), 32'(0));
    check_eq("rst_mul_ab", 32'({mul_a, mul_b}), 32'(0));
    check_eq("rst_out_valid", 32'(out_valid), 32'(0));
    check_eq("rst_out_prod", 32'(out_prod), 32'(0));
    check_eq("rst_done_cnt", 32'(done_cnt), 32'(0));
    rst_n = 1'b1;

    // Single op right after reset release, with latency measurement.
    base   = ms_cnt;
    lat_en = 1;
    push(4'd3, 4'd5);
    drain(100);
    check_eq("single_starts", 32'(ms_cnt - base), 32'(1));
    check_eq("single_done", 32'(done_cnt), 32'(1));

    // Operand extremes.
    push(4'd15, 4'd15);
    drain(100);
    push(4'd0, 4'd9);
    drain(100);
    check_eq("extreme_done", 32'(done_cnt), 32'(3));

    // Backpressure: product held while a second pair waits in the FIFO.
    out_ready = 1'b0;
    push(4'd7, 4'd8);
    t = 0;
    while (!out_valid && t < 50) begin step(1); t++; end
    check_eq("bp_valid", 32'(out_valid), 32'(1));
    held = 8'd56;
    base = ms_cnt;
    push(4'd9, 4'd9);
    hold_chk = 1;
    step(20);
    hold_chk = 0;
    check_eq("bp_no_start", 32'(ms_cnt - base), 32'(0));
    check_eq("bp_prod", 32'(out_prod), 32'(56));
    out_ready = 1'b1;
    drain(100);
    check_eq("bp_restart", 32'(ms_cnt - base), 32'(1));
    check_eq("bp_done", 32'(done_cnt), 32'(5));

    // FIFO full: back-to-back pushes while busy; last pair must stall.
    do_reset();
    stall_cnt = 0;
    push(4'd2, 4'd3);
    push(4'd4, 4'd5);
    push(4'd6, 4'd7);
    check_eq("full_in_ready", 32'(in_ready), 32'(0));
    push(4'd8, 4'd9);
    check_eq("full_stalled", 32'(stall_cnt != 0), 32'(1));
    drain(200);
    check_eq("full_done", 32'(done_cnt), 32'(4));

    // Reset mid-WAIT when the down-counter reads 3.
    push(4'd5, 4'd5);
    t = 0;
    while (!mul_start && t < 20) begin step(1); t++; end
    check_eq("mw_start_seen", 32'(mul_start), 32'(1));
    step(4);
    rst_n = 1'b0;
    #1;
    check_eq("mw_out_valid", 32'(out_valid), 32'(0));
    check_eq("mw_out_prod", 32'(out_prod), 32'(0));
    check_eq("mw_mul_ab", 32'({mul_a, mul_b, mul_start}), 32'(0));
    check_eq("mw_done_cnt", 32'(done_cnt), 32'(0));
    sb.delete();
    step(10);
    check_eq("mw_no_valid", 32'(out_valid), 32'(0));
    rst_n = 1'b1;
    push(4'd2, 4'd2);
    drain(100);
    check_eq("mw_after_done", 32'(done_cnt), 32'(1));

    // done_cnt wrap after 256 deliveries.
    do_reset();
    for (int i = 0; i < 256; i++) push(4'($urandom_range(15)), 4'($urandom_range(15)));
    drain(200);
    check_eq("wrap_done_cnt", 32'(done_cnt), 32'(0));
    check_eq("wrap_sb_empty", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
